// File: rtl/sha256_golden_nonce_checker.sv
// Golden-nonce checker on the second SHA-256 hash: delay-matched nonce tracking, word-7 share test,
// result FIFO with valid/ready drain and hit/drop counters. Define CHECKER_DIFF_EN to add target_mask.
module sha256_golden_nonce_checker #(
  parameter int unsigned LATENCY = 69,
  parameter int unsigned DEPTH   = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         issue_valid,
  input  logic [31:0]  nonce_in,
  input  logic [255:0] hash_in,
  input  logic         flush,
`ifdef CHECKER_DIFF_EN
  input  logic [31:0]  target_mask,
`endif
  output logic         golden_valid,
  output logic [31:0]  golden_nonce,
  input  logic         golden_ready,
  output logic [31:0]  hit_count,
  output logic [15:0]  drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [LATENCY-1:0] vld_pipe;
  logic [31:0]        nonce_pipe [LATENCY];
  logic [31:0]        mask;
  logic               match, match_q;
  logic [31:0]        nonce_q;
  logic [31:0]        mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic               full, pop, hit, push, drop;
  logic               unused_hash;

`ifdef CHECKER_DIFF_EN
  assign mask = target_mask;
`else
  assign mask = 32'hFFFF_FFFF;
`endif

  assign unused_hash = ^hash_in[223:0];
  assign match = vld_pipe[LATENCY-1] && ((hash_in[255:224] & mask) == 32'd0);

  // Nonce payload needs no reset; only the valid tags decide whether a tail is live.
  always_ff @(posedge clk) begin
    nonce_pipe[0] <= nonce_in;
    for (int i = 1; i < int'(LATENCY); i++) nonce_pipe[i] <= nonce_pipe[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      match_q  <= 1'b0;
      nonce_q  <= '0;
    end else begin
      if (flush) vld_pipe <= '0;
      else begin
        vld_pipe[0] <= issue_valid;
        for (int i = 1; i < int'(LATENCY); i++) vld_pipe[i] <= vld_pipe[i-1];
      end
      match_q <= match && !flush;
      nonce_q <= nonce_pipe[LATENCY-1];
    end
  end

  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop  = golden_valid && golden_ready && !flush;
  assign hit  = match_q && !flush;
  assign push = hit && (!full || pop);
  assign drop = hit && full && !pop;

  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      if (push) wr_nxt = wr_ptr + PTR_ONE;
      if (pop)  rd_nxt = rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= nonce_q;
  end

  // Head is registered: forward nonce_q when the new head slot is being written this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      golden_valid <= 1'b0;
      golden_nonce <= '0;
      hit_count    <= '0;
      drop_count   <= '0;
    end else begin
      wr_ptr       <= wr_nxt;
      rd_ptr       <= rd_nxt;
      golden_valid <= (wr_nxt != rd_nxt);
      if (wr_nxt != rd_nxt)
        golden_nonce <= (push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) ? nonce_q
                                                                      : mem[rd_nxt[AW-1:0]];
      if (push) hit_count <= hit_count + 32'd1;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sha256_golden_nonce_checker.sv
// Directed + randomized bench for sha256_golden_nonce_checker against a queue-based event model.
module tb_sha256_golden_nonce_checker;
  localparam int L = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         issue_valid;
  logic [31:0]  nonce_in;
  logic [255:0] hash_in;
  logic         flush;
  logic [31:0]  target_mask;
  logic         golden_valid;
  logic [31:0]  golden_nonce;
  logic         golden_ready;
  logic [31:0]  hit_count;
  logic [15:0]  drop_count;

  always #5 clk = ~clk;

  sha256_golden_nonce_checker #(.LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .nonce_in(nonce_in),
    .hash_in(hash_in), .flush(flush),
`ifdef CHECKER_DIFF_EN
    .target_mask(target_mask),
`endif
    .golden_valid(golden_valid), .golden_nonce(golden_nonce), .golden_ready(golden_ready),
    .hit_count(hit_count), .drop_count(drop_count)
  );

  typedef struct { logic [31:0] n; int c; } ev_t;
  ev_t         infl[$];  // issued nonces with their compare cycle
  ev_t         pend[$];  // qualified hits with their push-decision cycle
  logic [31:0] fq[$];    // model FIFO contents
  logic [31:0] m_hit;
  logic [15:0] m_drop;
  int          cyc;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] eff_mask();
`ifdef CHECKER_DIFF_EN
    return target_mask;
`else
    return 32'hFFFF_FFFF;
`endif
  endfunction

  task automatic model_check(input string tag);
    chk({tag, "_valid"}, {31'd0, golden_valid}, {31'd0, fq.size() > 0});
    if (fq.size() > 0) chk({tag, "_nonce"}, golden_nonce, fq[0]);
    chk({tag, "_hits"}, hit_count, m_hit);
    chk({tag, "_drops"}, {16'd0, drop_count}, {16'd0, m_drop});
  endtask

  // One clock: drive inputs, advance the model by the rules, then compare after the edge.
  task automatic step(input logic iv, input logic [31:0] n, input logic [31:0] w7,
                      input logic fl, input logic rdy);
    bit  pop, full;
    ev_t e;
    issue_valid  = iv;
    nonce_in     = n;
    hash_in      = {w7, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    flush        = fl;
    golden_ready = rdy;
    full = (fq.size() == D);
    pop  = (fq.size() > 0) && rdy && !fl;
    if (pop) void'(fq.pop_front());
    if (pend.size() > 0 && pend[0].c == cyc) begin
      e = pend.pop_front();
      if (!fl) begin
        if (!full || pop) begin fq.push_back(e.n); m_hit++; end
        else if (m_drop != 16'hFFFF) m_drop++;
      end
    end
    if (infl.size() > 0 && infl[0].c == cyc) begin
      e = infl.pop_front();
      if (!fl && ((w7 & eff_mask()) == 32'd0)) pend.push_back('{e.n, cyc + 1});
    end
    if (fl) begin infl.delete(); pend.delete(); fq.delete(); end
    if (iv && !fl) infl.push_back('{n, cyc + L});
    @(posedge clk); #1;
    cyc++;
    model_check("step");
  endtask

  task automatic idle(input int k, input logic [31:0] w7, input logic rdy);
    for (int i = 0; i < k; i++) step(1'b0, 32'd0, w7, 1'b0, rdy);
  endtask

  logic [31:0] snap_hit;
  logic [15:0] snap_drop;

  initial begin
    reset_n = 1'b0; issue_valid = 0; nonce_in = 0; hash_in = '1; flush = 0;
    golden_ready = 0; target_mask = 32'hFFFF_FFFF;
    m_hit = 0; m_drop = 0; cyc = 0;
    #23;
    chk("rst_valid", {31'd0, golden_valid}, 32'd0);
    chk("rst_nonce", golden_nonce, 32'd0);
    chk("rst_hits",  hit_count, 32'd0);
    chk("rst_drops", {16'd0, drop_count}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Single hit: issue at cycle 10, zero word 7 at 13, visible at 15.
    idle(10, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(2, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 32'd0, 32'h0000_0000, 1'b0, 1'b0);
    idle(1, 32'hFFFF_FFFF, 1'b0);
    chk("hit_valid", {31'd0, golden_valid}, 32'd1);
    chk("hit_nonce", golden_nonce, 32'h1234_5678);
    chk("hit_count", hit_count, 32'd1);
    idle(1, 32'hFFFF_FFFF, 1'b1);

    // Non-hit: word 7 = 1.
    step(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(2, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 32'd0, 32'h0000_0001, 1'b0, 1'b0);
    idle(3, 32'hFFFF_FFFF, 1'b0);
    chk("nohit_valid", {31'd0, golden_valid}, 32'd0);
    chk("nohit_count", hit_count, 32'd1);

    // Overflow: six hits with ready low.
    for (int i = 1; i <= 6; i++) step(1'b1, i, 32'd0, 1'b0, 1'b0);
    idle(5, 32'd0, 1'b0);
    chk("ovf_drops", {16'd0, drop_count}, 32'd2);
    chk("ovf_hits", hit_count, 32'd5);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", golden_nonce, i);
      idle(1, 32'd0, 1'b1);
    end
    chk("ovf_empty", {31'd0, golden_valid}, 32'd0);

    // Full FIFO with a same-cycle pop accepts nonce 5.
    for (int i = 1; i <= 5; i++) step(1'b1, i, 32'd0, 1'b0, 1'b0);
    idle(3, 32'd0, 1'b0);
    idle(1, 32'd0, 1'b1);
    chk("fullpop_drops", {16'd0, drop_count}, 32'd2);
    chk("fullpop_hits", hit_count, 32'd10);
    for (int i = 2; i <= 5; i++) begin
      chk("fullpop_order", golden_nonce, i);
      idle(1, 32'd0, 1'b1);
    end

    // Flush with one entry stored and two nonces in flight.
    step(1'b1, 32'h0000_000A, 32'd0, 1'b0, 1'b0);
    idle(4, 32'd0, 1'b0);
    step(1'b1, 32'h0000_000B, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_000C, 32'd0, 1'b0, 1'b0);
    snap_hit = hit_count; snap_drop = drop_count;
    step(1'b1, 32'h0000_000D, 32'd0, 1'b1, 1'b0);
    chk("flush_valid", {31'd0, golden_valid}, 32'd0);
    idle(L + 3, 32'd0, 1'b0);
    chk("flush_valid_after", {31'd0, golden_valid}, 32'd0);
    chk("flush_hits", hit_count, snap_hit);
    chk("flush_drops", {16'd0, drop_count}, {16'd0, snap_drop});

    // Mask behaviour for word 7 = 0x0000ABCD.
    target_mask = 32'hFFFF_0000;
    step(1'b1, 32'h0000_0ABC, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(2, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 32'd0, 32'h0000_ABCD, 1'b0, 1'b0);
    idle(1, 32'hFFFF_FFFF, 1'b0);
`ifdef CHECKER_DIFF_EN
    chk("mask_hit", {31'd0, golden_valid}, 32'd1);
`else
    chk("mask_nohit", {31'd0, golden_valid}, 32'd0);
`endif
    target_mask = 32'hFFFF_FFFF;
    idle(1, 32'hFFFF_FFFF, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      logic [31:0] w;
      w = ($urandom_range(0, 2) == 0) ? 32'd0 : ($urandom_range(0, 1) ? ($urandom & 32'h0000_FFFF) : $urandom);
`ifdef CHECKER_DIFF_EN
      if (i % 100 == 0) target_mask = $urandom_range(0, 1) ? 32'hFFFF_0000 : 32'hFFFF_FFFF;
`endif
      step($urandom_range(0, 3) != 0, $urandom, w, $urandom_range(0, 59) == 0,
           $urandom_range(0, 2) == 0);
    end

    // Asynchronous reset mid-stream with entries pending.
    for (int i = 1; i <= 3; i++) step(1'b1, 32'h100 + i, 32'd0, 1'b0, 1'b0);
    idle(L + 2, 32'hFFFF_FFFF, 1'b0);
    chk("prerst_valid", {31'd0, golden_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, golden_valid}, 32'd0);
    chk("arst_hits", hit_count, 32'd0);
    chk("arst_drops", {16'd0, drop_count}, 32'd0);
    infl.delete(); pend.delete(); fq.delete(); m_hit = 0; m_drop = 0;
    #2 reset_n = 1'b1;
    @(posedge clk); #1; cyc++;
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom, ($urandom_range(0, 1) ? 32'd0 : $urandom), 1'b0,
           $urandom_range(0, 3) == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
